// File: rtl/s2mm_pkg.sv
// Shared definitions for the S2MM capture path: FSM states, DataMover status
// bit positions, err_code bit positions and the burst-count helper.
package s2mm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } s2mm_state_e;

    localparam int STS_OKAY   = 7;
    localparam int STS_SLVERR = 6;
    localparam int STS_DECERR = 5;
    localparam int STS_INTERR = 4;

    localparam int ERR_SLV  = 0;
    localparam int ERR_DEC  = 1;
    localparam int ERR_INT  = 2;
    localparam int ERR_SPUR = 3;
    localparam int ERR_TO   = 4;
    localparam int ERR_CFG  = 5;

    // Round-up division by the burst size; the 33-bit sum keeps a capture
    // near 4 GiB from wrapping before the shift.
    function automatic logic [31:0] burst_count(input logic [31:0] cap_size,
                                                input int unsigned lg_burst);
        logic [32:0] round_up;
        logic [32:0] sum;
        round_up = (33'd1 << lg_burst) - 33'd1;
        sum      = {1'b0, cap_size} + round_up;
        return 32'(sum >> lg_burst);
    endfunction

endpackage

// File: rtl/s2mm_wdog.sv
// Hang watchdog: down-counter reloaded by clr, decremented while en is high,
// expire asserts while enabled at terminal count zero.
module s2mm_wdog #(
    parameter int unsigned WIDTH = 20
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             expire
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/axis_sts_mon_s2mm.sv
// S2MM completion monitor: counts outstanding DataMover commands against
// returned status words and reports done, DataMover errors, spurious status and hangs.
//
//  state | meaning
//  IDLE  | waiting for write_start; any status here is spurious
//  RUN   | capture in flight; counting commands, statuses and idle time
//  DONE  | every expected burst returned OKAY; wr_done high
//  ERROR | something went wrong; wr_error high, err_code keeps accumulating
module axis_sts_mon_s2mm
    import s2mm_pkg::*;
#(
    parameter int unsigned MAX_BURST_LEN  = 4096,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned OUTST_WIDTH    = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   cmd_tvalid,
    input  logic                   cmd_tready,
    input  logic [7:0]             s_axis_sts_tdata,
    input  logic                   s_axis_sts_tvalid,
    output logic                   s_axis_sts_tready,
    input  logic                   s_axis_sts_tkeep,
    input  logic                   s_axis_sts_tlast,
    input  logic                   write_start,
    input  logic                   write_reset,
    input  logic [31:0]            cap_size,
    output logic                   wr_done,
    output logic                   wr_error,
    output logic [5:0]             err_code,
    output logic [31:0]            sts_cnt,
    output logic [OUTST_WIDTH-1:0] outstanding
);

    localparam int unsigned LG_BURST = $clog2(MAX_BURST_LEN);
    localparam int unsigned TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT_CYCLES - 1);

    s2mm_state_e            state_q, state_d;
    logic [OUTST_WIDTH-1:0] outst_q, outst_d;
    logic [31:0]            cnt_q, cnt_d;
    logic [31:0]            exp_q, exp_d;
    logic [5:0]             err_q, err_d;

    logic       cmd_hs, sts_hs;
    logic       outst_zero, outst_full, dec;
    logic       okay, slv, decerr, intr;
    logic [2:0] sts_err_bits;
    logic       sts_is_err;
    logic       spurious;
    logic       wdog_clr, wdog_exp;
    logic       unused_sts;

    // The DataMover is never backpressured outside reset.
    assign s_axis_sts_tready = resetn;

    assign cmd_hs     = cmd_tvalid & cmd_tready;
    assign sts_hs     = s_axis_sts_tvalid & s_axis_sts_tready;
    assign outst_zero = (outst_q == '0);
    assign outst_full = &outst_q;
    assign dec        = sts_hs && !outst_zero;

    assign okay   = s_axis_sts_tdata[STS_OKAY];
    assign slv    = s_axis_sts_tdata[STS_SLVERR];
    assign decerr = s_axis_sts_tdata[STS_DECERR];
    assign intr   = s_axis_sts_tdata[STS_INTERR];

    // A bare OKAY=0 with no cause bits is reported as an internal error.
    assign sts_err_bits = {intr | (!okay & !slv & !decerr), decerr, slv};
    assign sts_is_err   = |sts_err_bits;

    // The generator always issues tag 0, so TAG and the framing bits carry nothing.
    assign unused_sts = ^{s_axis_sts_tdata[3:0], s_axis_sts_tkeep, s_axis_sts_tlast};

    always_comb begin
        state_d  = state_q;
        outst_d  = outst_q;
        cnt_d    = cnt_q;
        exp_d    = exp_q;
        err_d    = err_q;
        wdog_clr = 1'b1;
        spurious = 1'b0;

        if (sts_hs) begin
            cnt_d = cnt_q + 32'd1;
        end

        if (cmd_hs && !dec) begin
            if (!outst_full) begin
                outst_d = outst_q + OUTST_WIDTH'(1);
            end
        end else if (dec && !cmd_hs) begin
            outst_d = outst_q - OUTST_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (sts_hs) begin
                    spurious = 1'b1;
                end else if (write_start) begin
                    if (cap_size != '0) begin
                        exp_d   = burst_count(cap_size, LG_BURST);
                        cnt_d   = '0;
                        outst_d = '0;
                        state_d = RUN;
                    end else begin
                        err_d[ERR_CFG] = 1'b1;
                        state_d        = ERROR;
                    end
                end
            end
            RUN: begin
                wdog_clr = sts_hs || outst_zero;
                if (sts_hs) begin
                    // Status beyond the expected count means generator and monitor disagree.
                    if (outst_zero || (cnt_q == exp_q)) begin
                        spurious = 1'b1;
                    end
                    if (sts_is_err) begin
                        err_d[ERR_INT:ERR_SLV] = err_q[ERR_INT:ERR_SLV] | sts_err_bits;
                        state_d                = ERROR;
                    end else if (!spurious && (cnt_d == exp_q) && (outst_d == '0)) begin
                        state_d = DONE;
                    end
                end
                if (wdog_exp) begin
                    err_d[ERR_TO] = 1'b1;
                    state_d       = ERROR;
                end
            end
            DONE: begin
                if (sts_hs) begin
                    spurious = 1'b1;
                end
            end
            ERROR: begin
                if (sts_hs) begin
                    err_d[ERR_INT:ERR_SLV] = err_q[ERR_INT:ERR_SLV] | sts_err_bits;
                    if (outst_zero) begin
                        spurious = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (spurious) begin
            err_d[ERR_SPUR] = 1'b1;
            state_d         = ERROR;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || write_reset) begin
            state_q <= IDLE;
            outst_q <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            outst_q <= outst_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            err_q   <= err_d;
        end
    end

    s2mm_wdog #(
        .WIDTH (TW)
    ) u_wdog (
        .clk      (clk),
        .resetn   (resetn),
        .clr      (wdog_clr),
        .en       (state_q == RUN),
        .load_val (T_LOAD),
        .expire   (wdog_exp)
    );

    assign wr_done     = (state_q == DONE);
    assign wr_error    = (state_q == ERROR);
    assign err_code    = err_q;
    assign sts_cnt     = cnt_q;
    assign outstanding = outst_q;

endmodule

// File: tb/tb_axis_sts_mon_s2mm.sv
// Scoreboard bench for axis_sts_mon_s2mm: stimulus queues hand-computed
// output snapshots tagged with the cycle they apply to; a negedge monitor compares them.
module tb_axis_sts_mon_s2mm;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_tvalid, cmd_tready;
    logic [7:0]  s_axis_sts_tdata;
    logic        s_axis_sts_tvalid, s_axis_sts_tready;
    logic        s_axis_sts_tkeep, s_axis_sts_tlast;
    logic        write_start, write_reset;
    logic [31:0] cap_size;
    logic        wr_done, wr_error;
    logic [5:0]  err_code;
    logic [31:0] sts_cnt;
    logic [7:0]  outstanding;

    always #5 clk = ~clk;

    axis_sts_mon_s2mm #(
        .MAX_BURST_LEN  (4096),
        .TIMEOUT_CYCLES (100),
        .OUTST_WIDTH    (8)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .cmd_tvalid        (cmd_tvalid),
        .cmd_tready        (cmd_tready),
        .s_axis_sts_tdata  (s_axis_sts_tdata),
        .s_axis_sts_tvalid (s_axis_sts_tvalid),
        .s_axis_sts_tready (s_axis_sts_tready),
        .s_axis_sts_tkeep  (s_axis_sts_tkeep),
        .s_axis_sts_tlast  (s_axis_sts_tlast),
        .write_start       (write_start),
        .write_reset       (write_reset),
        .cap_size          (cap_size),
        .wr_done           (wr_done),
        .wr_error          (wr_error),
        .err_code          (err_code),
        .sts_cnt           (sts_cnt),
        .outstanding       (outstanding)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [95:0] nm;
        logic        d;
        logic        e;
        logic [5:0]  ec;
        logic [31:0] sc;
        logic [7:0]  os;
        logic        rdy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    logic flush_req = 1'b0;

    always @(negedge clk) begin
        exp_t x;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            x = exp_q.pop_front();
            checks++;
            if (x.cyc != cyc ||
                {wr_done, wr_error, err_code, sts_cnt, outstanding, s_axis_sts_tready} !==
                {x.d, x.e, x.ec, x.sc, x.os, x.rdy}) begin
                failures++;
                $display("FAIL %0s cyc=%0d got done=%0b err=%0b code=%b cnt=%0d outst=%0d rdy=%0b want done=%0b err=%0b code=%b cnt=%0d outst=%0d rdy=%0b",
                         x.nm, cyc, wr_done, wr_error, err_code, sts_cnt, outstanding, s_axis_sts_tready,
                         x.d, x.e, x.ec, x.sc, x.os, x.rdy);
            end
        end
        if (flush_req) begin
            while (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                failures++;
                $display("FAIL %0s never sampled, due at cyc %0d", x.nm, x.cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input int dly, input logic [95:0] nm, input logic d, input logic e,
                            input logic [5:0] ec, input logic [31:0] sc, input logic [7:0] os,
                            input logic rdy);
        exp_t x;
        x.cyc = cyc + dly;
        x.nm  = nm;
        x.d   = d;
        x.e   = e;
        x.ec  = ec;
        x.sc  = sc;
        x.os  = os;
        x.rdy = rdy;
        exp_q.push_back(x);
    endtask

    // Expectation for the state just produced by the last clock edge.
    task automatic chk(input logic [95:0] nm, input logic d, input logic e,
                       input logic [5:0] ec, input logic [31:0] sc, input logic [7:0] os);
        push_exp(0, nm, d, e, ec, sc, os, 1'b1);
    endtask

    task automatic drive(input logic c, input logic s, input logic [7:0] data,
                         input logic st, input logic [31:0] cap, input logic wr);
        cmd_tvalid        = c;
        cmd_tready        = c;
        s_axis_sts_tvalid = s;
        s_axis_sts_tdata  = data;
        write_start       = st;
        cap_size          = cap;
        write_reset       = wr;
        tick(1);
        cmd_tvalid        = 1'b0;
        cmd_tready        = 1'b0;
        s_axis_sts_tvalid = 1'b0;
        s_axis_sts_tdata  = 8'h00;
        write_start       = 1'b0;
        write_reset       = 1'b0;
    endtask

    task automatic cmd();              drive(1'b1, 1'b0, 8'h00, 1'b0, 32'd0, 1'b0); endtask
    task automatic sts(input logic [7:0] d); drive(1'b0, 1'b1, d, 1'b0, 32'd0, 1'b0); endtask
    task automatic start(input logic [31:0] c); drive(1'b0, 1'b0, 8'h00, 1'b1, c, 1'b0); endtask
    task automatic sreset();           drive(1'b0, 1'b0, 8'h00, 1'b0, 32'd0, 1'b1); endtask

    initial begin
        resetn            = 1'b0;
        cmd_tvalid        = 1'b0;
        cmd_tready        = 1'b0;
        s_axis_sts_tdata  = 8'h00;
        s_axis_sts_tvalid = 1'b0;
        s_axis_sts_tkeep  = 1'b1;
        s_axis_sts_tlast  = 1'b1;
        write_start       = 1'b0;
        write_reset       = 1'b0;
        cap_size          = 32'd0;

        tick(2);
        push_exp(0, "reset", 1'b0, 1'b0, 6'b000000, 32'd0, 8'd0, 1'b0);
        tick(1);
        resetn = 1'b1;
        chk("post_reset", 0, 0, 6'b000000, 0, 0);

        // normal run: 10000 bytes -> 3 bursts
        start(32'd10000);  chk("n_start", 0, 0, 6'b000000, 0, 0);
        cmd();             chk("n_cmd1",  0, 0, 6'b000000, 0, 1);
        cmd();             chk("n_cmd2",  0, 0, 6'b000000, 0, 2);
        cmd();             chk("n_cmd3",  0, 0, 6'b000000, 0, 3);
        sts(8'h80);        chk("n_sts1",  0, 0, 6'b000000, 1, 2);
        sts(8'h80);        chk("n_sts2",  0, 0, 6'b000000, 2, 1);
        sts(8'h80);        chk("n_done",  1, 0, 6'b000000, 3, 0);
        tick(1);           chk("n_hold",  1, 0, 6'b000000, 3, 0);
        sreset();          chk("n_srst",  0, 0, 6'b000000, 0, 0);

        // SLVERR on the second status
        start(32'd10000);
        cmd(); cmd(); cmd();
        sts(8'h80);        chk("e_sts1",  0, 0, 6'b000000, 1, 2);
        sts(8'h40);        chk("e_slv",   0, 1, 6'b000001, 2, 1);
        sts(8'h80);        chk("e_nodone",0, 1, 6'b000001, 3, 0);
        sreset();          chk("e_srst",  0, 0, 6'b000000, 0, 0);

        // command and status in the same cycle
        start(32'd10000);
        cmd();             chk("s_cmd1",  0, 0, 6'b000000, 0, 1);
        drive(1'b1, 1'b1, 8'h80, 1'b0, 32'd0, 1'b0);
                           chk("s_both",  0, 0, 6'b000000, 1, 1);
        sts(8'h80);        chk("s_sts2",  0, 0, 6'b000000, 2, 0);
        cmd();             chk("s_cmd3",  0, 0, 6'b000000, 2, 1);
        sts(8'h80);        chk("s_done",  1, 0, 6'b000000, 3, 0);
        sreset();

        // hang: one command, no status, TIMEOUT_CYCLES=100
        start(32'd10000);
        cmd();             chk("t_cmd",   0, 0, 6'b000000, 0, 1);
        push_exp(99,  "t_before", 1'b0, 1'b0, 6'b000000, 32'd0, 8'd1, 1'b1);
        push_exp(100, "t_expire", 1'b0, 1'b1, 6'b010000, 32'd0, 8'd1, 1'b1);
        tick(101);
        sreset();          chk("t_srst",  0, 0, 6'b000000, 0, 0);

        // spurious status in IDLE, then zero-size start
        sts(8'h80);        chk("p_idle",  0, 1, 6'b001000, 1, 0);
        sreset();
        start(32'd0);      chk("p_cfg",   0, 1, 6'b100000, 0, 0);
        sreset();

        // ceiling boundary: 4097 bytes -> 2 bursts
        start(32'd4097);
        cmd();
        sts(8'h80);        chk("b_sts1",  0, 0, 6'b000000, 1, 0);
        cmd();
        sts(8'h80);        chk("b_done",  1, 0, 6'b000000, 2, 0);
        sreset();

        // more commands than expected bursts: extra status is spurious
        start(32'd4096);
        cmd(); cmd();
        sts(8'h80);        chk("m_sts1",  0, 0, 6'b000000, 1, 1);
        sts(8'h80);        chk("m_extra", 0, 1, 6'b001000, 2, 0);
        sreset();

        // soft reset mid-run, then single-burst capture and late status in DONE
        start(32'd10000);
        cmd(); cmd(); cmd();
        sts(8'h80);        chk("r_sts1",  0, 0, 6'b000000, 1, 2);
        sreset();          chk("r_srst",  0, 0, 6'b000000, 0, 0);
        start(32'd4096);
        cmd();             chk("r_cmd",   0, 0, 6'b000000, 0, 1);
        sts(8'h80);        chk("r_done",  1, 0, 6'b000000, 1, 0);
        sts(8'h80);        chk("r_late",  0, 1, 6'b001000, 2, 0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick(1);
        flush_req = 1'b1;
        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_sts_mon_s2mm.md
Name: axis_sts_mon_s2mm

Overview:
Downstream completion monitor for the S2MM capture path. It watches the command handshake between the S2MM command generator and the DataMover, and consumes the DataMover 8-bit S2MM status stream. It tracks how many commands are still outstanding and counts returned status words. It declares the capture done only when every burst has been written to memory, and flags DataMover errors, spurious status words and hangs to the control registers.

Parameters:
MAX_BURST_LEN, 4096, bytes per command; must match the command generator and be a power of two.
TIMEOUT_CYCLES, 1000000, cycles with commands outstanding and no status before a hang is declared; minimum 2.
OUTST_WIDTH, 8, width of the outstanding-command counter.

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
cmd_tvalid  in  1  snoop of generator m_axis_tvalid
cmd_tready  in  1  snoop of DataMover cmd tready
s_axis_sts_tdata  in  8  DataMover status: [7] OKAY, [6] SLVERR, [5] DECERR, [4] INTERR, [3:0] TAG
s_axis_sts_tvalid  in  1  status valid
s_axis_sts_tready  out  1  status ready
s_axis_sts_tkeep  in  1  ignored
s_axis_sts_tlast  in  1  ignored
write_start  in  1  capture start, same signal the generator receives
write_reset  in  1  synchronous soft reset
cap_size  in  32  total capture bytes, sampled on start
wr_done  out  1  all bursts completed OK; level signal
wr_error  out  1  error latched; level signal
err_code  out  6  {cfg, timeout, spurious, INTERR, DECERR, SLVERR}; sticky
sts_cnt  out  32  status words accepted since start
outstanding  out  OUTST_WIDTH  commands issued minus statuses returned

Behaviour:
- Reset (resetn=0 at a clk edge) sets all outputs and state to 0, with state = IDLE. write_reset has the same effect and is lower priority than resetn only.
- s_axis_sts_tready is 0 during reset and 1 at all other times. The block never backpressures the DataMover.
- On write_start in IDLE with cap_size != 0:
  - latch exp_bursts = (cap_size + MAX_BURST_LEN-1) >> log2(MAX_BURST_LEN), using a 33-bit sum;
  - clear sts_cnt, outstanding and the timer;
  - go to RUN.
- On write_start in IDLE with cap_size == 0: set err_code[5] and go to ERROR.
- write_start is ignored outside IDLE.
- Command handshake (cmd_tvalid & cmd_tready) increments outstanding. A status handshake decrements it. Both in the same cycle leaves it unchanged.
  - Increment saturates at all-ones.
  - A status arriving while outstanding == 0 is spurious: set err_code[3], hold outstanding at 0, go to ERROR.
  - In IDLE, any status handshake is spurious.
- Each accepted status increments sts_cnt, which wraps at 2^32.
- A status is an error if OKAY=0 or any of SLVERR/DECERR/INTERR is set. On an error: OR bits [6:4] into err_code[0], err_code[1] and err_code[2] respectively, then go to ERROR. OKAY=0 with no error bits set maps to INTERR.
- TAG is ignored because the generator issues tag 0.
- Timer (RUN only):
  - clears on any status handshake or when outstanding == 0;
  - otherwise increments each cycle;
  - at TIMEOUT_CYCLES-1, set err_code[4] and go to ERROR.
- RUN to DONE: in the cycle after the accepted OKAY status brings sts_cnt to exp_bursts with the updated outstanding == 0. wr_done goes to 1 on that edge.
- If sts_cnt reaches exp_bursts while outstanding > 0, the later status is handled as spurious. This is a generator/monitor mismatch.
- DONE: wr_done holds 1. Any further status is spurious: go to ERROR and clear wr_done.
- ERROR: wr_error holds 1. Later error bits still OR into err_code.
- Both DONE and ERROR exit only through write_reset or resetn.
- Error priority within one cycle: a status error and a timeout in the same cycle set both bits.

Decomposition:
- Package s2mm_pkg holds:
  - the state enum {IDLE, RUN, DONE, ERROR};
  - status bit indices (STS_OKAY=7, STS_SLVERR=6, STS_DECERR=5, STS_INTERR=4);
  - err_code indices (ERR_SLV=0 to ERR_CFG=5);
  - a function computing the burst count.
- The generator reuses the same package.
- One sub-module, s2mm_wdog: a loadable timeout counter with clear, enable and expire pins.

Test Plan:
- Normal run: MAX=4096, cap_size=10000 → exp_bursts=3. Three cmd handshakes, three statuses of 0x80 → wr_done=1 one cycle after the third status; sts_cnt=3, outstanding=0, err_code=0.
- Error status: same setup, second status 0x40 (SLVERR, OKAY=0) → wr_error=1, err_code=6'b000001, wr_done never asserts.
- Simultaneous events: a cmd handshake and a status handshake in the same cycle with outstanding=1 → outstanding stays 1, sts_cnt increments by 1.
- Timeout: TIMEOUT_CYCLES=100, one cmd accepted, no status → wr_error rises exactly 100 cycles after the cmd handshake; err_code=6'b010000.
- Spurious and config errors: a status 0x80 in IDLE → err_code[3]=1. Separately, write_start with cap_size=0 → err_code[5]=1.
- Soft reset mid-run: write_reset asserted after 1 of 3 statuses → the next cycle has all outputs 0 and state IDLE. A following start with cap_size=4096 completes with a single status.
